fp_add_sub_pipe: RTL and testbench

FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

---
 rtl/fp_add_sub_pipe.sv | 154 +++++++++++++++
 tb/tb_fp_add_sub_pipe.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: 3-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Optional macro FP_ADD_SUB_RNE_EN: round to nearest even with inf on overflow.
// Without it the block truncates and saturates to max finite on overflow.
// Ports: i_clk, i_rst_n (async active-low); i_valid/o_ready with i_mode (0 add, 1 sub), i_a, i_b;
//        o_valid/i_ready with o_result and o_flags {invalid, overflow, inexact}.
module fp_add_sub_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic [EXP_W+FRAC_W:0] i_a,
    input  logic [EXP_W+FRAC_W:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [EXP_W+FRAC_W:0] o_result,
    output logic [2:0]            o_flags
);
    localparam int W = 1 + EXP_W + FRAC_W;
    localparam int M = FRAC_W + 4;  // hidden + fraction + guard/round/sticky
    localparam logic [EXP_W-1:0] EMAX = '1;
`ifdef FP_ADD_SUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam logic [W-2:0] OVF_MAG = RNE ? {EMAX, {FRAC_W{1'b0}}} : {EMAX - 1'b1, {FRAC_W{1'b1}}};

    logic w_en;
    logic r1_v, r1_sign, r1_sub, r1_nan, r1_inv, r1_inf, r1_infs;
    logic [EXP_W-1:0] r1_exp;
    logic [M-1:0] r1_big, r1_small;
    logic r2_v, r2_sign, r2_zero, r2_uf, r2_nan, r2_inv, r2_inf, r2_infs;
    logic [EXP_W:0] r2_exp;
    logic [M-1:0] r2_mant;
    logic r_v;
    logic [W-1:0] r_res;
    logic [2:0] r_flags;

    assign w_en     = ~(r_v & ~i_ready);
    assign o_ready  = w_en;
    assign o_valid  = r_v;
    assign o_result = r_res;
    assign o_flags  = r_flags;

    // S1: classify, order by magnitude, align the smaller significand
    logic [EXP_W-1:0] w_ae, w_be, w_le, w_se, w_d;
    logic [FRAC_W-1:0] w_af, w_bf, w_lf, w_sf;
    logic w_bs, w_swap, w_ls, w_anan, w_bnan, w_ainf, w_binf, w_snan, w_ii;
    logic [M-1:0] w_lm, w_sm, w_sh, w_al;
    always_comb begin
        w_ae   = i_a[W-2:FRAC_W];
        w_be   = i_b[W-2:FRAC_W];
        w_af   = (w_ae == '0) ? '0 : i_a[FRAC_W-1:0];
        w_bf   = (w_be == '0) ? '0 : i_b[FRAC_W-1:0];
        w_bs   = i_b[W-1] ^ i_mode;
        w_anan = (w_ae == EMAX) && (i_a[FRAC_W-1:0] != '0);
        w_bnan = (w_be == EMAX) && (i_b[FRAC_W-1:0] != '0);
        w_ainf = (w_ae == EMAX) && (i_a[FRAC_W-1:0] == '0);
        w_binf = (w_be == EMAX) && (i_b[FRAC_W-1:0] == '0);
        w_snan = (w_anan & ~i_a[FRAC_W-1]) | (w_bnan & ~i_b[FRAC_W-1]);
        w_ii   = w_ainf & w_binf & (i_a[W-1] ^ w_bs);
        w_swap = {w_be, w_bf} > {w_ae, w_af};
        w_le   = w_swap ? w_be : w_ae;
        w_se   = w_swap ? w_ae : w_be;
        w_lf   = w_swap ? w_bf : w_af;
        w_sf   = w_swap ? w_af : w_bf;
        w_ls   = w_swap ? w_bs : i_a[W-1];
        w_d    = w_le - w_se;
        w_lm   = {w_le != '0, w_lf, 3'b000};
        w_sm   = {w_se != '0, w_sf, 3'b000};
        w_sh   = w_sm >> w_d;
        // bits shifted past the sticky position are ORed back into it
        w_al   = (32'(w_d) >= FRAC_W + 3) ? M'(w_sm != '0)
                                          : {w_sh[M-1:1], w_sh[0] | ((w_sh << w_d) != w_sm)};
    end

    // S2: add/subtract magnitudes, then normalise
    logic [M:0] w_sum;
    logic [M-1:0] w_nm;
    int w_lz, w_ne;
    logic w_zero, w_uf, w_zs;
    always_comb begin
        w_sum = r1_sub ? {1'b0, r1_big} - {1'b0, r1_small} : {1'b0, r1_big} + {1'b0, r1_small};
        w_lz  = 0;
        for (int i = 0; i < M; i++) if (w_sum[i]) w_lz = M - 1 - i;
        w_ne   = w_sum[M] ? int'(r1_exp) + 1 : int'(r1_exp) - w_lz;
        w_nm   = w_sum[M] ? {w_sum[M:2], w_sum[1] | w_sum[0]} : w_sum[M-1:0] << w_lz;
        w_zero = (w_sum == '0) || (w_ne < 1);
        w_uf   = (w_sum != '0) && (w_ne < 1);
        // exact cancellation is +0; an all-zero add keeps the operand sign
        w_zs   = r1_sign & ~(r1_sub & (w_sum == '0));
    end

    // S3: round, detect overflow, select specials, pack
    logic w_up, w_inx, w_ovf;
    logic [FRAC_W+1:0] w_rs;
    logic [EXP_W:0] w_fe;
    logic [W-1:0] w_res;
    logic [2:0] w_flg;
    always_comb begin
        w_inx = |r2_mant[2:0];
        w_up  = RNE & r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
        w_rs  = {1'b0, r2_mant[M-1:3]} + (FRAC_W+2)'(w_up);
        w_fe  = r2_exp + (EXP_W+1)'(w_rs[FRAC_W+1]);
        w_ovf = w_fe >= {1'b0, EMAX};
        w_res = r2_nan  ? {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}} :
                r2_inf  ? {r2_infs, EMAX, {FRAC_W{1'b0}}} :
                r2_zero ? {r2_sign, {(W-1){1'b0}}} :
                w_ovf   ? {r2_sign, OVF_MAG} :
                          {r2_sign, w_fe[EXP_W-1:0], w_rs[FRAC_W-1:0]};
        w_flg = r2_nan  ? {r2_inv, 2'b00} :
                r2_inf  ? 3'b000 :
                r2_zero ? {2'b00, r2_uf} :
                w_ovf   ? 3'b011 : {2'b00, w_inx};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r1_v <= 1'b0; r1_sign <= 1'b0; r1_sub <= 1'b0; r1_nan <= 1'b0; r1_inv <= 1'b0;
            r1_inf <= 1'b0; r1_infs <= 1'b0; r1_exp <= '0; r1_big <= '0; r1_small <= '0;
            r2_v <= 1'b0; r2_sign <= 1'b0; r2_zero <= 1'b0; r2_uf <= 1'b0; r2_nan <= 1'b0;
            r2_inv <= 1'b0; r2_inf <= 1'b0; r2_infs <= 1'b0; r2_exp <= '0; r2_mant <= '0;
            r_v <= 1'b0; r_res <= '0; r_flags <= '0;
        end else if (w_en) begin
            r1_v     <= i_valid;
            r1_sign  <= w_ls;
            r1_sub   <= i_a[W-1] ^ w_bs;
            r1_nan   <= w_anan | w_bnan | w_ii;
            r1_inv   <= w_snan | w_ii;
            r1_inf   <= w_ainf | w_binf;
            r1_infs  <= w_ainf ? i_a[W-1] : w_bs;
            r1_exp   <= w_le;
            r1_big   <= w_lm;
            r1_small <= w_al;
            r2_v     <= r1_v;
            r2_sign  <= w_zs;
            r2_zero  <= w_zero;
            r2_uf    <= w_uf;
            r2_nan   <= r1_nan;
            r2_inv   <= r1_inv;
            r2_inf   <= r1_inf;
            r2_infs  <= r1_infs;
            r2_exp   <= (EXP_W+1)'(w_ne);
            r2_mant  <= w_nm;
            r_v      <= r2_v;
            r_res    <= w_res;
            r_flags  <= w_flg;
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb_fp_add_sub_pipe: scoreboard bench for fp_add_sub_pipe with directed single-precision vectors
module tb_fp_add_sub_pipe;
    logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_mode = 1'b0, i_ready = 1'b1;
    logic [31:0] i_a = '0, i_b = '0;
    logic o_ready, o_valid;
    logic [31:0] o_result;
    logic [2:0] o_flags;
    int total = 0, bad = 0, cyc = 0, stall_cnt = 0;
    bit seen_head = 0;
    typedef struct { logic [31:0] r; logic [2:0] f; int c; bit l; } exp_t;
    exp_t q[$];
    logic [31:0] ints [0:10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                 32'h41100000, 32'h41200000, 32'h41300000};
`ifdef FP_ADD_SUB_RNE_EN
    localparam logic [31:0] R_TIE = 32'h3F800002, R_OVF = 32'h7F800000;
`else
    localparam logic [31:0] R_TIE = 32'h3F800001, R_OVF = 32'h7F7FFFFF;
`endif

    fp_add_sub_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
        .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_flags(o_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // result is due 3 cycles after the cycle in which it was accepted
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [31:0] r, input logic [2:0] f, input bit l);
        bit ok = 0;
        i_valid = 1'b1; i_a = a; i_b = b; i_mode = m;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready;
        end
        if (ok) q.push_back('{r, f, cyc, l});
        else chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        #1 chk("drain_pending", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen_head = 0;
        else begin
            chk("o_ready", 32'(o_ready), 32'(!(o_valid && !i_ready)));
            if (!o_ready) stall_cnt++;
            if (o_valid) begin
                if (q.size() == 0) chk("spurious_valid", 32'(o_valid), 32'd0);
                else begin
                    chk("result", o_result, q[0].r);
                    chk("flags", 32'(o_flags), 32'(q[0].f));
                    if (!seen_head && q[0].l) chk("latency", cyc - q[0].c, 3);
                    seen_head = 1;
                    if (i_ready) begin
                        void'(q.pop_front());
                        seen_head = 0;
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_ready", 32'(o_ready), 1);
        chk("rst_o_result", o_result, 0);
        chk("rst_o_flags", 32'(o_flags), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 1'b1);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1'b1);
        send(32'h3F800001, 32'h33800000, 1'b0, R_TIE,        3'b001, 1'b1);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 1'b1);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, R_OVF,        3'b011, 1'b1);
        send(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001, 1'b1);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 1'b1);
        send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1'b1);
        send(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000, 1'b1);
        send(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 1'b1);
        send(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1'b1);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 1'b1);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 1'b1);
        send(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, 1'b1);
        send(32'h3F800001, 32'h3F800000, 1'b0, 32'h40000000, 3'b001, 1'b1);
        drain();
        stall_cnt = 0;
        fork
            for (int k = 0; k < 10; k++) send(ints[k], 32'h3F800000, 1'b0, ints[k+1], 3'b000, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        chk("stall_cycles", stall_cnt, 4);
        i_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        @(negedge clk);
        chk("inflight_valid", 32'(o_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 0);
        chk("midrst_o_ready", 32'(o_ready), 1);
        chk("midrst_o_result", o_result, 0);
        chk("midrst_o_flags", 32'(o_flags), 0);
        q.delete();
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 3'b000, 1'b1);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b1);
        drain();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
